// File: rtl/unstripe_lane_scheduler_pkg.sv
// Shared types and constants for the two-lane un-striping scheduler.
// FSM encodings, default widths and the FIFO pointer-width helper.
package unstripe_lane_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ALIGN  = 2'd1,
        ST_SEND_0 = 2'd2,
        ST_SEND_1 = 2'd3
    } state_e;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned DEPTH_DEF  = 4;

    // Index width for a power-of-two FIFO; the pointers carry one extra wrap bit.
    function automatic int unsigned ptr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/unstripe_lane_fifo.sv
// Per-lane synchronous FIFO with asynchronous reset and a synchronous flush.
// Head word and full/empty status are combinational views of the registered state.
module unstripe_lane_fifo
    import unstripe_lane_scheduler_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] head_c,
    output logic              full_c,
    output logic              empty_c
);

    localparam int unsigned PW = ptr_w(DEPTH);

    logic [PW:0]       wr_q, wr_d;
    logic [PW:0]       rd_q, rd_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    assign empty_c = (wr_q == rd_q);
    assign full_c  = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
    assign head_c  = mem_q[rd_q[PW-1:0]];

    // Flush wins over any same-cycle push or pop.
    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (flush_i) begin
            wr_d = '0;
            rd_d = '0;
        end else begin
            if (push_i) wr_d = wr_q + (PW+1)'(1);
            if (pop_i)  rd_d = rd_q + (PW+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_q[PW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/unstripe_lane_scheduler.sv
// Two-lane un-striping scheduler: buffers both lanes, aligns them and emits 0,1,0,1 words.
// Optional UNSTRIPE_ERR_CNT_EN adds a saturating 8-bit error counter output err_count.
module unstripe_lane_scheduler
    import unstripe_lane_scheduler_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned DEPTH    = DEPTH_DEF,
    parameter int unsigned SKEW_MAX = 3
) (
    input  logic              clk_2f,
    input  logic              reset,
    input  logic              valid_0,
    input  logic [DATA_W-1:0] lane_0,
    input  logic              valid_1,
    input  logic [DATA_W-1:0] lane_1,
    output logic              valid_out,
    output logic [DATA_W-1:0] Data_out,
    output logic              sel_lane,
    output logic              aligned,
    output logic              skew_err,
    output logic              overflow_err
`ifdef UNSTRIPE_ERR_CNT_EN
    ,
    output logic [7:0]        err_count
`endif
);

    localparam int unsigned CNT_W = $clog2(SKEW_MAX + 1);
    localparam logic [CNT_W-1:0] SKEW_LIM = CNT_W'(SKEW_MAX);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  skew_cnt_q, skew_cnt_d, skew_inc;
    logic              valid_q, sel_q, aligned_q, skew_q, ovf_q;
    logic [DATA_W-1:0] data_q;

    logic              full0, full1, empty0, empty1;
    logic [DATA_W-1:0] head0, head1;
    logic              pop0, pop1, flush, timeout;
    logic              push0, push1, drop0, drop1;

    assign push0 = valid_0 && (!full0 || pop0) && !flush;
    assign push1 = valid_1 && (!full1 || pop1) && !flush;
    assign drop0 = valid_0 && full0 && !pop0;
    assign drop1 = valid_1 && full1 && !pop1;
    assign skew_inc = skew_cnt_q + CNT_W'(1);

    unstripe_lane_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo0 (
        .clk(clk_2f), .rst(reset), .flush_i(flush), .push_i(push0), .wdata_i(lane_0),
        .pop_i(pop0), .head_c(head0), .full_c(full0), .empty_c(empty0)
    );

    unstripe_lane_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo1 (
        .clk(clk_2f), .rst(reset), .flush_i(flush), .push_i(push1), .wdata_i(lane_1),
        .pop_i(pop1), .head_c(head1), .full_c(full1), .empty_c(empty1)
    );

    // Next-state logic; a missing lane advances the skew counter until it times out.
    always_comb begin
        state_d    = state_q;
        skew_cnt_d = skew_cnt_q;
        pop0       = 1'b0;
        pop1       = 1'b0;
        timeout    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty0 && !empty1) begin
                    state_d    = ST_SEND_0;
                    skew_cnt_d = '0;
                end else if (empty0 != empty1) begin
                    state_d    = ST_ALIGN;
                    skew_cnt_d = CNT_W'(1);
                end
            end
            ST_ALIGN: begin
                if (!empty0 && !empty1) begin
                    state_d    = ST_SEND_0;
                    skew_cnt_d = '0;
                end else if (skew_inc == SKEW_LIM) begin
                    timeout = 1'b1;
                end else begin
                    skew_cnt_d = skew_inc;
                end
            end
            ST_SEND_0: begin
                if (!empty0) begin
                    pop0       = 1'b1;
                    state_d    = ST_SEND_1;
                    skew_cnt_d = '0;
                end else if (empty1) begin
                    state_d    = ST_IDLE;
                    skew_cnt_d = '0;
                end else if (skew_inc == SKEW_LIM) begin
                    timeout = 1'b1;
                end else begin
                    skew_cnt_d = skew_inc;
                end
            end
            ST_SEND_1: begin
                if (!empty1) begin
                    pop1       = 1'b1;
                    state_d    = ST_SEND_0;
                    skew_cnt_d = '0;
                end else if (skew_inc == SKEW_LIM) begin
                    timeout = 1'b1;
                end else begin
                    skew_cnt_d = skew_inc;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (timeout) begin
            state_d    = ST_IDLE;
            skew_cnt_d = '0;
        end
    end

    assign flush = timeout;

    always_ff @(posedge clk_2f or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            skew_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            skew_cnt_q <= skew_cnt_d;
        end
    end

    // Output registers; Data_out keeps its last word while valid_out is low.
    always_ff @(posedge clk_2f or posedge reset) begin
        if (reset) begin
            valid_q   <= 1'b0;
            data_q    <= '0;
            sel_q     <= 1'b0;
            aligned_q <= 1'b0;
            skew_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            valid_q   <= pop0 || pop1;
            sel_q     <= pop1;
            aligned_q <= (state_d == ST_SEND_0) || (state_d == ST_SEND_1);
            skew_q    <= timeout;
            ovf_q     <= ovf_q || drop0 || drop1;
            if (pop0)      data_q <= head0;
            else if (pop1) data_q <= head1;
        end
    end

    assign valid_out    = valid_q;
    assign Data_out     = data_q;
    assign sel_lane     = sel_q;
    assign aligned      = aligned_q;
    assign skew_err     = skew_q;
    assign overflow_err = ovf_q;

`ifdef UNSTRIPE_ERR_CNT_EN
    logic [7:0] err_cnt_q;
    logic [9:0] err_sum;

    assign err_sum = 10'(err_cnt_q) + 10'(timeout) + 10'(drop0) + 10'(drop1);

    always_ff @(posedge clk_2f or posedge reset) begin
        if (reset) err_cnt_q <= '0;
        else       err_cnt_q <= (err_sum > 10'd255) ? 8'hFF : err_sum[7:0];
    end

    assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_unstripe_lane_scheduler.sv
// Self-checking bench for unstripe_lane_scheduler against a queue-based lane model.
// Honours UNSTRIPE_ERR_CNT_EN when defined.
module tb_unstripe_lane_scheduler;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 4;
    localparam int          SKEW  = 3;

    logic          clk_2f = 1'b0;
    logic          reset  = 1'b1;
    logic          valid_0 = 1'b0, valid_1 = 1'b0;
    logic [DW-1:0] lane_0 = '0, lane_1 = '0;

    logic          valid_out, sel_lane, aligned, skew_err, overflow_err;
    logic [DW-1:0] Data_out;
    logic          b_valid_out, b_sel_lane, b_aligned, b_skew_err, b_overflow_err;
    logic [DW-1:0] b_Data_out;
`ifdef UNSTRIPE_ERR_CNT_EN
    logic [7:0]    err_count, b_err_count;
`endif

    logic [DW+4:0] obs_w, exp_w;
    assign obs_w = {valid_out, sel_lane, aligned, skew_err, overflow_err, Data_out};

    int errors = 0;
    int checks = 0;

    always #5 clk_2f = ~clk_2f;

    unstripe_lane_scheduler #(.DATA_W(DW), .DEPTH(DEPTH), .SKEW_MAX(SKEW)) dut (
        .clk_2f(clk_2f), .reset(reset),
        .valid_0(valid_0), .lane_0(lane_0), .valid_1(valid_1), .lane_1(lane_1),
        .valid_out(valid_out), .Data_out(Data_out), .sel_lane(sel_lane),
        .aligned(aligned), .skew_err(skew_err), .overflow_err(overflow_err)
`ifdef UNSTRIPE_ERR_CNT_EN
        , .err_count(err_count)
`endif
    );

    // Long skew window so a single lane can fill its FIFO before timing out.
    unstripe_lane_scheduler #(.DATA_W(DW), .DEPTH(DEPTH), .SKEW_MAX(8)) dut_ovf (
        .clk_2f(clk_2f), .reset(reset),
        .valid_0(valid_0), .lane_0(lane_0), .valid_1(valid_1), .lane_1(lane_1),
        .valid_out(b_valid_out), .Data_out(b_Data_out), .sel_lane(b_sel_lane),
        .aligned(b_aligned), .skew_err(b_skew_err), .overflow_err(b_overflow_err)
`ifdef UNSTRIPE_ERR_CNT_EN
        , .err_count(b_err_count)
`endif
    );

    // Reference model: lane queues, a streaming flag, the lane wanted next, a missing-run length.
    logic [DW-1:0] q0[$], q1[$];
    bit            m_stream;
    int            m_want, m_missing, m_err;
    bit            m_ovf;
    logic [DW-1:0] m_data;

    task automatic model_reset();
        q0.delete(); q1.delete();
        m_stream = 0; m_want = 0; m_missing = 0; m_err = 0;
        m_ovf = 0; m_data = '0;
        exp_w = '0;
    endtask

    task automatic model_step(input bit a0, input logic [DW-1:0] x0,
                              input bit a1, input logic [DW-1:0] x1);
        bit has0, has1, p0, p1, fl, dr0, dr1, wait_tick;
        has0 = (q0.size() != 0);
        has1 = (q1.size() != 0);
        p0 = 0; p1 = 0; fl = 0; wait_tick = 0;
        if (!m_stream) begin
            if (has0 && has1) begin
                m_stream = 1; m_want = 0; m_missing = 0;
            end else if (has0 || has1) begin
                wait_tick = 1;
            end
        end else if ((m_want == 0) ? has0 : has1) begin
            if (m_want == 0) p0 = 1; else p1 = 1;
            m_want = 1 - m_want;
            m_missing = 0;
        end else if (m_want == 0 && !has1) begin
            m_stream = 0; m_missing = 0;
        end else begin
            wait_tick = 1;
        end
        if (wait_tick) begin
            if (m_missing + 1 == SKEW) fl = 1;
            else m_missing = m_missing + 1;
        end
        dr0 = a0 && (q0.size() == DEPTH) && !p0;
        dr1 = a1 && (q1.size() == DEPTH) && !p1;
        if (p0) m_data = q0.pop_front();
        if (p1) m_data = q1.pop_front();
        if (fl) begin
            q0.delete(); q1.delete();
            m_stream = 0; m_missing = 0;
        end else begin
            if (a0 && !dr0) q0.push_back(x0);
            if (a1 && !dr1) q1.push_back(x1);
        end
        m_ovf = m_ovf || dr0 || dr1;
        m_err = m_err + int'(fl) + int'(dr0) + int'(dr1);
        if (m_err > 255) m_err = 255;
        exp_w = {p0 || p1, p1, m_stream, fl, m_ovf, m_data};
    endtask

    task automatic step(input bit a0, input logic [DW-1:0] x0,
                        input bit a1, input logic [DW-1:0] x1);
        @(negedge clk_2f);
        valid_0 = a0; lane_0 = x0; valid_1 = a1; lane_1 = x1;
        model_step(a0, x0, a1, x1);
        @(posedge clk_2f);
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        repeat (3) @(posedge clk_2f);
        #1;
        checks++;
        if (obs_w !== '0) begin
            errors++; $display("FAIL reset_outputs got=%h exp=%h", obs_w, '0);
        end
        checks++;
        if ({b_valid_out, b_sel_lane, b_aligned, b_skew_err, b_overflow_err, b_Data_out} !== '0) begin
            errors++; $display("FAIL reset_outputs_b got=%b%b%b%b%b %h exp=0", b_valid_out,
                               b_sel_lane, b_aligned, b_skew_err, b_overflow_err, b_Data_out);
        end
`ifdef UNSTRIPE_ERR_CNT_EN
        checks++;
        if (err_count !== 8'd0 || b_err_count !== 8'd0) begin
            errors++; $display("FAIL reset_err_count got=%0d/%0d exp=0", err_count, b_err_count);
        end
`endif
        @(negedge clk_2f);
        reset = 1'b0;
    endtask

    task automatic test_aligned_burst();
        int first_idx, got_n;
        logic [DW-1:0] want;
        first_idx = -1; got_n = 0;
        for (int i = 0; i < 14; i++) begin
            step(i < 4, 32'hA0 + 32'(i), i < 4, 32'hB0 + 32'(i));
            checks++;
            if (obs_w !== exp_w) begin
                errors++; $display("FAIL burst_model i=%0d got=%h exp=%h", i, obs_w, exp_w);
            end
            if (valid_out) begin
                if (first_idx < 0) first_idx = i;
                want = ((got_n % 2) == 0) ? 32'hA0 + 32'(got_n / 2) : 32'hB0 + 32'(got_n / 2);
                checks++;
                if (Data_out !== want || sel_lane !== 1'(got_n % 2) || i != first_idx + got_n) begin
                    errors++; $display("FAIL burst_order n=%0d i=%0d got=%h sel=%b exp=%h", got_n, i,
                                       Data_out, sel_lane, want);
                end
                got_n++;
            end
        end
        checks++;
        if (first_idx != 2 || got_n != 8 || aligned !== 1'b0) begin
            errors++; $display("FAIL burst_shape first=%0d words=%0d aligned=%b exp first=2 words=8 aligned=0",
                               first_idx, got_n, aligned);
        end
    endtask

    task automatic test_lag(input int lag, input int n, input int exp_words, input int exp_skews);
        int got_n, skews;
        logic [DW-1:0] want;
        got_n = 0; skews = 0;
        for (int i = 0; i < lag + n + 12; i++) begin
            step(i < n, 32'hA0 + 32'(i), (i >= lag) && (i < lag + n), 32'hB0 + 32'(i - lag));
            checks++;
            if (obs_w !== exp_w) begin
                errors++; $display("FAIL lag%0d_model i=%0d got=%h exp=%h", lag, i, obs_w, exp_w);
            end
            if (skew_err) skews++;
            if (valid_out) begin
                want = ((got_n % 2) == 0) ? 32'hA0 + 32'(got_n / 2) : 32'hB0 + 32'(got_n / 2);
                checks++;
                if (Data_out !== want) begin
                    errors++; $display("FAIL lag%0d_order n=%0d got=%h exp=%h", lag, got_n, Data_out, want);
                end
                got_n++;
            end
        end
        checks++;
        if (got_n != exp_words || skews != exp_skews) begin
            errors++; $display("FAIL lag%0d_summary words=%0d skews=%0d exp words=%0d skews=%0d",
                               lag, got_n, skews, exp_words, exp_skews);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 11; i++) begin
            step(i < 6, 32'hC0 + 32'(i), 1'b0, '0);
            checks++;
            if (obs_w !== exp_w) begin
                errors++; $display("FAIL ovf_model i=%0d got=%h exp=%h", i, obs_w, exp_w);
            end
            checks++;
            if (b_overflow_err !== (i >= 4)) begin
                errors++; $display("FAIL ovf_flag i=%0d got=%b exp=%b", i, b_overflow_err, i >= 4);
            end
            checks++;
            if ({b_valid_out, b_sel_lane, b_aligned, b_skew_err} !== {3'b000, 1'(i == 8)}) begin
                errors++; $display("FAIL ovf_flags_b i=%0d got=%b%b%b%b exp=000%b", i, b_valid_out,
                                   b_sel_lane, b_aligned, b_skew_err, i == 8);
            end
        end
    endtask

    task automatic test_starve();
        int got_n, skews, skew_idx;
        logic [DW-1:0] want;
        got_n = 0; skews = 0; skew_idx = -1;
        for (int i = 0; i < 16; i++) begin
            step(i < 4, 32'hA0 + 32'(i), i < 2, 32'hB0 + 32'(i));
            checks++;
            if (obs_w !== exp_w) begin
                errors++; $display("FAIL starve_model i=%0d got=%h exp=%h", i, obs_w, exp_w);
            end
            if (skew_err) begin skews++; skew_idx = i; end
            if (valid_out) begin
                want = ((got_n % 2) == 0) ? 32'hA0 + 32'(got_n / 2) : 32'hB0 + 32'(got_n / 2);
                checks++;
                if (Data_out !== want) begin
                    errors++; $display("FAIL starve_order n=%0d got=%h exp=%h", got_n, Data_out, want);
                end
                got_n++;
            end
        end
        checks++;
        if (got_n != 5 || skews != 1 || skew_idx != 9) begin
            errors++; $display("FAIL starve_summary words=%0d skews=%0d at=%0d exp 5/1/9",
                               got_n, skews, skew_idx);
        end
    endtask

    task automatic test_async_reset();
        int first_idx;
        checks++;
        if (b_overflow_err !== 1'b1) begin
            errors++; $display("FAIL ovf_sticky got=%b exp=1", b_overflow_err);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'hC0 + 32'(i), 1'b1, 32'hD0 + 32'(i));
            checks++;
            if (obs_w !== exp_w) begin
                errors++; $display("FAIL arst_pre i=%0d got=%h exp=%h", i, obs_w, exp_w);
            end
        end
        #2;
        reset = 1'b1; valid_0 = 1'b0; valid_1 = 1'b0;
        model_reset();
        #1;
        checks++;
        if (obs_w !== '0 || b_overflow_err !== 1'b0) begin
            errors++; $display("FAIL arst_immediate got=%h ovf_b=%b exp=0", obs_w, b_overflow_err);
        end
        @(negedge clk_2f);
        @(negedge clk_2f);
        reset = 1'b0;
        first_idx = -1;
        for (int i = 0; i < 12; i++) begin
            step(i < 4, 32'hE0 + 32'(i), i < 4, 32'hF0 + 32'(i));
            checks++;
            if (obs_w !== exp_w) begin
                errors++; $display("FAIL arst_post i=%0d got=%h exp=%h", i, obs_w, exp_w);
            end
            if (valid_out && first_idx < 0) begin
                first_idx = i;
                checks++;
                if (Data_out !== 32'hE0 || sel_lane !== 1'b0 || i != 2) begin
                    errors++; $display("FAIL arst_first i=%0d got=%h sel=%b exp=e0 sel=0 i=2",
                                       i, Data_out, sel_lane);
                end
            end
        end
    endtask

    task automatic test_random();
        int pat;
        bit a0, a1;
        pat = 0;
        for (int i = 0; i < 600; i++) begin
            if (i % 16 == 0) pat = int'($urandom_range(0, 3));
            case (pat)
                0: begin a0 = ($urandom_range(0, 9) < 9); a1 = a0; end
                1: begin a0 = 1'b1; a1 = ($urandom_range(0, 3) == 0); end
                2: begin a0 = $urandom_range(0, 1) == 1; a1 = $urandom_range(0, 1) == 1; end
                default: begin a0 = 1'b0; a1 = 1'b0; end
            endcase
            step(a0, $urandom, a1, $urandom);
            checks++;
            if (obs_w !== exp_w) begin
                errors++; $display("FAIL random_model i=%0d got=%h exp=%h", i, obs_w, exp_w);
            end
`ifdef UNSTRIPE_ERR_CNT_EN
            checks++;
            if (err_count !== 8'(m_err)) begin
                errors++; $display("FAIL random_err_count i=%0d got=%0d exp=%0d", i, err_count, m_err);
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_aligned_burst();
        test_lag(2, 4, 8, 0);
        test_lag(3, 1, 0, 1);
        test_overflow();
        test_starve();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
